// File: rtl/signed_divider_if.sv
// signed_divider_if: start/busy/done handshake and operand/result bus for the divider.
interface signed_divider_if #(parameter int N = 32);
  logic         start;
  logic         is_signed;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;
  modport master (output start, is_signed, dividend, divisor,
                  input busy, done, quotient, remainder, div_by_zero);
  modport slave (input start, is_signed, dividend, divisor,
                 output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/signed_divider.sv
// signed_divider: multi-cycle restoring signed/unsigned divider with start/busy/done handshake.
// Optional DIVIDER_FAST_ZERO_EN: a zero divisor skips the iterations and finishes from PREP.
module signed_divider #(
  parameter int N = 32
) (
  input logic clk,
  input logic reset,
  signed_divider_if.slave bus
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_ITER = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam int CW = $clog2(N + 1);
  logic [2:0]   r_state;
  logic [N-1:0] r_a, r_b, r_mag_b, r_rem, r_quo;
  logic [N-1:0] r_quotient, r_remainder;
  logic         r_sgn, r_neg_a, r_neg_b, r_dbz;
  logic [CW-1:0] r_cnt;
  logic         w_neg_a, w_neg_b, w_zero;
  logic [N:0]   w_sh, w_trial;
  logic [N-1:0] w_q_fix, w_r_fix;
  assign w_neg_a = r_sgn & r_a[N-1];
  assign w_neg_b = r_sgn & r_b[N-1];
  assign w_zero  = r_b == '0;
  assign w_sh    = {r_rem, r_quo[N-1]};
  // The top bit of the N+1-bit trial difference is the borrow: set means the subtract fails.
  assign w_trial = w_sh - {1'b0, r_mag_b};
  assign w_q_fix = w_zero ? '1 : (r_neg_a ^ r_neg_b) ? -r_quo : r_quo;
  assign w_r_fix = w_zero ? r_a : r_neg_a ? -r_rem : r_rem;
  assign bus.busy        = (r_state == S_PREP) || (r_state == S_ITER) || (r_state == S_FIX);
  assign bus.done        = r_state == S_DONE;
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_dbz;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_mag_b     <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_sgn       <= 1'b0;
      r_neg_a     <= 1'b0;
      r_neg_b     <= 1'b0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_a     <= bus.dividend;
          r_b     <= bus.divisor;
          r_sgn   <= bus.is_signed;
          r_state <= S_PREP;
        end
        S_PREP: begin
          r_neg_a <= w_neg_a;
          r_neg_b <= w_neg_b;
          r_quo   <= w_neg_a ? -r_a : r_a;
          r_mag_b <= w_neg_b ? -r_b : r_b;
          r_rem   <= '0;
          r_cnt   <= CW'(N);
          r_state <= S_ITER;
`ifdef DIVIDER_FAST_ZERO_EN
          if (w_zero) begin
            r_quotient  <= '1;
            r_remainder <= r_a;
            r_dbz       <= 1'b1;
            r_state     <= S_DONE;
          end
`endif
        end
        S_ITER: begin
          r_rem   <= w_trial[N] ? w_sh[N-1:0] : w_trial[N-1:0];
          r_quo   <= {r_quo[N-2:0], ~w_trial[N]};
          r_cnt   <= r_cnt - CW'(1);
          r_state <= (r_cnt == CW'(1)) ? S_FIX : S_ITER;
        end
        S_FIX: begin
          r_quotient  <= w_q_fix;
          r_remainder <= w_r_fix;
          r_dbz       <= w_zero;
          r_state     <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_signed_divider.sv
// tb_signed_divider: randomized and directed checks of signed_divider against an arithmetic model.
module tb_signed_divider;
  localparam int N = 32;
`ifdef DIVIDER_FAST_ZERO_EN
  localparam int ZERO_LAT = 2;
`else
  localparam int ZERO_LAT = N + 3;
`endif
  logic clk = 1'b0;
  logic reset;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  signed_divider_if #(.N(N)) bus ();
  signed_divider #(.N(N)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic void model(input logic s, input logic [N-1:0] a, input logic [N-1:0] b,
                                output logic [N-1:0] q, output logic [N-1:0] r, output logic z);
    longint sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    z = (b == 0);
    if (z) begin
      q = '1;
      r = a;
    end else if (s) begin
      q = N'(sa / sb);
      r = N'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction
  task automatic run_op(input logic s, input logic [N-1:0] a, input logic [N-1:0] b, input bit poke);
    logic [N-1:0] eq, er;
    logic ez;
    int lat, exp_lat, extra_done, extra_busy;
    bit busy_bad;
    model(s, a, b, eq, er, ez);
    exp_lat = (b == 0) ? ZERO_LAT : N + 3;
    @(negedge clk);
    bus.start = 1'b1;
    bus.is_signed = s;
    bus.dividend = a;
    bus.divisor = b;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    busy_bad = 0;
    while (!bus.done && lat < 100) begin
      if (!bus.busy) busy_bad = 1;
      if (poke && lat == 5) begin
        bus.start = 1'b1;
        bus.is_signed = ~s;
        bus.dividend = $urandom;
        bus.divisor = $urandom;
      end else bus.start = 1'b0;
      @(negedge clk);
      lat++;
    end
    check_eq("latency", 64'(lat), 64'(exp_lat));
    check_eq("busy_during_op", 64'(busy_bad), 64'(0));
    check_eq("busy_at_done", 64'(bus.busy), 64'(0));
    check_eq("quotient", 64'(bus.quotient), 64'(eq));
    check_eq("remainder", 64'(bus.remainder), 64'(er));
    check_eq("div_by_zero", 64'(bus.div_by_zero), 64'(ez));
    if (poke) begin
      bus.start = 1'b1;
      bus.dividend = $urandom;
      bus.divisor = $urandom;
    end
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("done_one_cycle", 64'(bus.done), 64'(0));
    if (poke) begin
      extra_done = 0;
      extra_busy = 0;
      for (int i = 0; i < 40; i++) begin
        if (bus.done) extra_done++;
        if (bus.busy) extra_busy++;
        @(negedge clk);
      end
      check_eq("poke_no_done", 64'(extra_done), 64'(0));
      check_eq("poke_no_busy", 64'(extra_busy), 64'(0));
      check_eq("poke_quotient_held", 64'(bus.quotient), 64'(eq));
      check_eq("poke_remainder_held", 64'(bus.remainder), 64'(er));
    end
  endtask
  initial begin
    logic [N-1:0] a, b;
    logic s;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    #12;
    check_eq("rst_busy", 64'(bus.busy), 64'(0));
    check_eq("rst_done", 64'(bus.done), 64'(0));
    check_eq("rst_quotient", 64'(bus.quotient), 64'(0));
    check_eq("rst_remainder", 64'(bus.remainder), 64'(0));
    check_eq("rst_dbz", 64'(bus.div_by_zero), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    run_op(1'b0, 32'd100, 32'd7, 0);
    run_op(1'b1, 32'hFFFFFFF9, 32'h2, 0);
    run_op(1'b1, 32'd7, 32'hFFFFFFFE, 0);
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 0);
    run_op(1'b0, 32'h80000000, 32'hFFFFFFFF, 0);
    run_op(1'b1, 32'd5, 32'd0, 0);
    run_op(1'b0, 32'd5, 32'd0, 0);
    run_op(1'b1, 32'hFFFFFFF0, 32'd0, 0);
    run_op(1'b1, 32'd1234567, 32'hFFFFFF85, 1);
    // reset during iteration must clear outputs without waiting for a clock edge
    @(negedge clk);
    bus.start = 1'b1;
    bus.is_signed = 1'b0;
    bus.dividend = 32'd1000;
    bus.divisor = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("midrst_busy", 64'(bus.busy), 64'(0));
    check_eq("midrst_done", 64'(bus.done), 64'(0));
    check_eq("midrst_quotient", 64'(bus.quotient), 64'(0));
    check_eq("midrst_remainder", 64'(bus.remainder), 64'(0));
    check_eq("midrst_dbz", 64'(bus.div_by_zero), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    run_op(1'b0, 32'd9, 32'd3, 0);
    for (int i = 0; i < 25; i++) begin
      s = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = 32'($urandom_range(1, 15));
        2: b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_op(s, a, b, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/signed_divider.md
# signed_divider

Multi-cycle signed/unsigned integer divider for the execution stage. It sequences operand sign handling (two's-complement negation of negative inputs), an N-step restoring shift-subtract core, and result sign fix-up. It exposes a start/busy/done handshake so the pipeline control can stall while a division is in flight.

## Interface
- N, default WORD_WIDTH (32): operand and result width.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a division; sampled only in IDLE.
- is_signed  input  1  1 = signed (two's complement) operands, 0 = unsigned; sampled with start.
- dividend  input  N  sampled with start.
- divisor  input  N  sampled with start.
- busy  output  1  high in PREP, ITERATE and FIXUP.
- done  output  1  one-cycle pulse; quotient/remainder valid in that cycle and held afterwards.
- quotient  output  N  registered result.
- remainder  output  N  registered result.
- div_by_zero  output  1  registered; set with the result when divisor == 0.

## Operation
- Reset (asynchronous, any state): state = IDLE, busy = 0, done = 0, quotient = 0, remainder = 0, div_by_zero = 0, internal iteration counter = 0.
- IDLE: on start = 1, latch the operands and is_signed, then go to PREP. Otherwise stay in IDLE.
- PREP (1 cycle):
  - neg_a = is_signed & dividend[N-1]; neg_b = is_signed & divisor[N-1].
  - Store magnitudes: negate an operand (~x + 1, N bits, carry dropped) if its neg flag is set.
  - Clear the partial remainder; load counter = N; go to ITERATE.
- ITERATE (N cycles, one quotient bit per cycle, MSB first):
  - Shift {rem, quo} left by one; trial = rem - |divisor| computed at N+1 bits.
  - If trial is non-negative: rem = trial and the quotient LSB = 1. Otherwise the quotient LSB = 0.
  - Decrement the counter; leave for FIXUP when it reaches 0.
- FIXUP (1 cycle):
  - quotient = neg_a ^ neg_b ? -quo : quo.
  - remainder = neg_a ? -rem : rem. The remainder sign follows the dividend.
  - Go to DONE.
- DONE (1 cycle): done = 1, busy = 0. Return to IDLE. start is ignored in this cycle.
- Divide by zero overrides the sign fix-up: quotient = all ones, remainder = dividend (original value), div_by_zero = 1.
- Signed overflow: the most-negative value divided by -1 gives quotient = most-negative value and remainder = 0. This falls out of the N-bit negation; no special case is needed.
- start while busy or in DONE is ignored. No queuing.
- Outputs change only in the FIXUP→DONE transition, on the fast path, or on reset.

## Timing
- Let edge 0 be the clock edge that samples start in IDLE.
- Normal path: PREP covers cycle 1, ITERATE covers cycles 2..N+1, FIXUP is cycle N+2, and done is high in cycle N+3. For N = 32, done occurs 35 cycles after start.
- busy goes high in the cycle after edge 0 and drops when done rises.
- The earliest next accepted start is sampled at the edge ending cycle N+4, i.e. one cycle after done.
- Results are registered, so there is no combinational path from the inputs to any output.

## Configuration
- DIVIDER_FAST_ZERO_EN defined:
  - PREP detects divisor == 0 and branches directly to DONE with the divide-by-zero result.
  - done is high in cycle 2 after start.
- DIVIDER_FAST_ZERO_EN undefined:
  - A zero divisor takes the full N+3 latency.
  - FIXUP applies the divide-by-zero override.
- Result values and div_by_zero are identical in both builds; only the latency differs.

## Test plan
- Unsigned 100 / 7, is_signed = 0 → quotient = 14, remainder = 2, div_by_zero = 0. done pulses exactly 35 cycles after start and lasts one cycle; busy is high for cycles 1..34.
- Signed -7 / 2 (0xFFFFFFF9 / 0x2) → quotient = 0xFFFFFFFD, remainder = 0xFFFFFFFF. Signed 7 / -2 → quotient = 0xFFFFFFFD, remainder = 1.
- Signed 0x80000000 / 0xFFFFFFFF → quotient = 0x80000000, remainder = 0. The same operands unsigned → quotient = 0, remainder = 0x80000000.
- Divisor 0, dividend 5 (signed, then unsigned) → quotient = 0xFFFFFFFF, remainder = 5, div_by_zero = 1. done arrives at cycle 2 with DIVIDER_FAST_ZERO_EN and at cycle 35 without it.
- Second start pulsed at cycles 5 and N+3 of an operation → both are ignored: a single done occurs and the first operation's results are unchanged.
- reset asserted mid-ITERATE (cycle 10) → busy, done, quotient, remainder and div_by_zero are 0 immediately, before the next clock. After release, a new start with 9 / 3 → quotient = 3, remainder = 0 with normal latency.
